// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pixel-generation blocks: default screen size,
// coordinate/colour widths and the fill controller state encoding.
package vga_pkg;

  localparam int XRES_DEF = 640;
  localparam int YRES_DEF = 480;

  localparam int X_W = 10;
  localparam int Y_W = 9;
  localparam int C_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    DRAW,
    FINISH
  } fill_state_t;

  // A rectangle with either dimension zero produces no pixels at all.
  function automatic logic is_empty(input logic [X_W-1:0] w, input logic [Y_W-1:0] h);
    return (w == '0) || (h == '0);
  endfunction

endpackage

// File: rtl/xy_offset_counter.sv
// Nested column/row offset counter that walks a w x h rectangle in raster
// order; `last` flags the final pixel so the controller can stop on it.
module xy_offset_counter
  import vga_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           en,
  input  logic [X_W-1:0] w,
  input  logic [Y_W-1:0] h,
  output logic [X_W-1:0] dx,
  output logic [Y_W-1:0] dy,
  output logic           last
);

  localparam logic [X_W-1:0] X_ONE = X_W'(1);
  localparam logic [Y_W-1:0] Y_ONE = Y_W'(1);

  logic x_wrap;
  logic y_wrap;

  assign x_wrap = (dx == w - X_ONE);
  assign y_wrap = (dy == h - Y_ONE);
  assign last   = x_wrap && y_wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dx <= '0;
      dy <= '0;
    end else if (load) begin
      dx <= '0;
      dy <= '0;
    end else if (en) begin
      if (x_wrap) begin
        dx <= '0;
        dy <= y_wrap ? '0 : dy + Y_ONE;
      end else begin
        dx <= dx + X_ONE;
      end
    end
  end

endmodule

// File: rtl/vga_rect_fill.sv
// Rectangle / full-screen fill engine feeding the VGA plot interface: one
// registered pixel per clock in raster order, off-screen pixels suppressed.
module vga_rect_fill
  import vga_pkg::*;
#(
  parameter int XRES = XRES_DEF,
  parameter int YRES = YRES_DEF
) (
  input  logic           CLOCK_50,
  input  logic           reset,
  input  logic           start,
  input  logic           clear,
  input  logic [X_W-1:0] x0,
  input  logic [Y_W-1:0] y0,
  input  logic [X_W-1:0] w,
  input  logic [Y_W-1:0] h,
  input  logic [C_W-1:0] color,
  output logic [X_W-1:0] VGA_X,
  output logic [Y_W-1:0] VGA_Y,
  output logic [C_W-1:0] VGA_COLOR,
  output logic           plot,
  output logic           busy,
  output logic           done
);

  // Sums are one bit wider than the coordinates so a rectangle hanging past
  // the far edge clips instead of wrapping back onto the screen.
  localparam logic [X_W:0]   X_LIM  = XRES[X_W:0];
  localparam logic [Y_W:0]   Y_LIM  = YRES[Y_W:0];
  localparam logic [X_W-1:0] X_FULL = XRES[X_W-1:0];
  localparam logic [Y_W-1:0] Y_FULL = YRES[Y_W-1:0];

  fill_state_t state;

  logic [X_W-1:0] x0_q;
  logic [Y_W-1:0] y0_q;
  logic [X_W-1:0] w_q;
  logic [Y_W-1:0] h_q;
  logic [C_W-1:0] color_q;

  logic [X_W-1:0] dx;
  logic [Y_W-1:0] dy;
  logic           last;
  logic           accept;
  logic [X_W:0]   x_sum;
  logic [Y_W:0]   y_sum;
  logic           on_screen;

  assign accept    = (state == IDLE) && (clear || (start && !is_empty(w, h)));
  assign x_sum     = {1'b0, x0_q} + {1'b0, dx};
  assign y_sum     = {1'b0, y0_q} + {1'b0, dy};
  assign on_screen = (x_sum < X_LIM) && (y_sum < Y_LIM);

  xy_offset_counter u_counter (
    .clk  (CLOCK_50),
    .rst  (reset),
    .load (accept),
    .en   (state == DRAW),
    .w    (w_q),
    .h    (h_q),
    .dx   (dx),
    .dy   (dy),
    .last (last)
  );

  // Outputs are registered one stage behind the state, so a request taken at
  // edge t shows its first pixel after edge t+1 and done one cycle past the last.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      x0_q      <= '0;
      y0_q      <= '0;
      w_q       <= '0;
      h_q       <= '0;
      color_q   <= '0;
      VGA_X     <= '0;
      VGA_Y     <= '0;
      VGA_COLOR <= '0;
      plot      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          plot <= 1'b0;
          busy <= 1'b0;
          done <= 1'b0;
          if (clear) begin
            x0_q    <= '0;
            y0_q    <= '0;
            w_q     <= X_FULL;
            h_q     <= Y_FULL;
            color_q <= color;
            state   <= DRAW;
          end else if (start) begin
            if (is_empty(w, h)) begin
              state <= FINISH;
            end else begin
              x0_q    <= x0;
              y0_q    <= y0;
              w_q     <= w;
              h_q     <= h;
              color_q <= color;
              state   <= DRAW;
            end
          end
        end

        DRAW: begin
          VGA_X     <= x_sum[X_W-1:0];
          VGA_Y     <= y_sum[Y_W-1:0];
          VGA_COLOR <= color_q;
          plot      <= on_screen;
          busy      <= 1'b1;
          done      <= 1'b0;
          if (last) begin
            state <= FINISH;
          end
        end

        FINISH: begin
          plot  <= 1'b0;
          busy  <= 1'b1;
          done  <= 1'b1;
          state <= IDLE;
        end

        default: begin
          plot  <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/vga_rect_fill.md
# vga_rect_fill

Pixel-generation engine that drives the DESim "VGA" plot interface (`VGA_X`, `VGA_Y`, `VGA_COLOR`, `plot`) of the `top` design. On a start pulse it latches a rectangle (origin, size, colour) and emits one plot pulse per pixel, raster order, one pixel per clock. Pixels that fall off-screen are clipped. A clear request fills the whole screen. It sits directly upstream of the simulated VGA display and is fed by switch/key or PS/2 control logic.

## Interface
- `XRES`, default 640: screen width in pixels.
- `YRES`, default 480: screen height in pixels.
- `CLOCK_50`  in  1   system clock, rising edge.
- `reset`  in  1   asynchronous, active-high reset.
- `start`  in  1   one-cycle request to draw the rectangle from `x0`/`y0`/`w`/`h`/`color`.
- `clear`  in  1   one-cycle request to fill the full screen with `color`; takes priority over `start` in the same cycle.
- `x0`  in  10   rectangle left column.
- `y0`  in  9   rectangle top row.
- `w`  in  10   width in pixels, 0 means empty.
- `h`  in  9   height in pixels, 0 means empty.
- `color`  in  3   pixel colour, 0 to 7.
- `VGA_X`  out  10   current pixel column.
- `VGA_Y`  out  9   current pixel row.
- `VGA_COLOR`  out  3   current pixel colour.
- `plot`  out  1   high for one cycle per pixel to be drawn.
- `busy`  out  1   high while a fill is in progress.
- `done`  out  1   one-cycle pulse when a fill completes.

## Operation
- States: IDLE, DRAW, FINISH.
- IDLE:
  - `clear`: latch origin (0,0), size (`XRES`,`YRES`) and `color`, then go to DRAW.
  - Else `start` with `w`≠0 and `h`≠0: latch the inputs, then go to DRAW.
  - Else `start` with `w`=0 or `h`=0: go to FINISH directly; no plot is emitted.
- DRAW:
  - Offset counters `dx` (10 b) and `dy` (9 b) start at 0.
  - Each cycle presents pixel (`x0`+`dx`, `y0`+`dy`).
  - `dx` increments each cycle. When `dx`=`w`−1 it wraps to 0 and `dy` increments.
  - When `dx`=`w`−1 and `dy`=`h`−1, go to FINISH.
- Clipping:
  - Sums are computed at 11 b (x) and 10 b (y).
  - If x ≥ `XRES` or y ≥ `YRES`, `plot` is 0 for that cycle. The counters still advance, so a rectangle always takes exactly `w`·`h` cycles.
  - `VGA_X`/`VGA_Y` carry the truncated low bits of the sums.
- FINISH: `done`=1 for one cycle, then go to IDLE.
- `start` and `clear` are ignored outside IDLE; they are not queued.
- Inputs are sampled only on the accepting cycle. Later changes do not affect a fill in progress.
- Reset mid-fill aborts at once. No further plot and no `done` are issued.

## Timing
- Reset values: `VGA_X`=0, `VGA_Y`=0, `VGA_COLOR`=0, `plot`=0, `busy`=0, `done`=0, state IDLE.
- All outputs are registered.
- Request at edge t: `busy`=1 and the first pixel (`plot` if on-screen) appear after edge t+1.
- The last pixel is presented in cycle t+`w`·`h`. `done` is high in cycle t+`w`·`h`+1, with `busy` still 1. `busy`=0 from the next cycle.
- An empty rectangle gives `busy`=1 and `done`=1 in cycle t+1 only.
- A new request is accepted in the first cycle after `done`.
- A full-screen clear takes 307200 plot cycles plus 1.

## Structure
- Shared package `vga_pkg` holds:
  - `XRES_DEF`=640, `YRES_DEF`=480;
  - widths `X_W`=10, `Y_W`=9, `C_W`=3;
  - the state enum `fill_state_t` {IDLE, DRAW, FINISH}.
- One sub-module, `xy_offset_counter`: the nested `dx`/`dy` counter with load, enable, `last` flag, and wrap at `w`−1/`h`−1.
- Control FSM, clipping compare and output registers live in `vga_rect_fill`.

## Test plan
- Reset during operation → all outputs 0 on the same edge, asynchronously; no `done` afterwards.
- `start` with `x0`=10, `y0`=20, `w`=3, `h`=2, `color`=5:
  - exactly 6 plots at (10,20), (11,20), (12,20), (10,21), (11,21), (12,21), all with colour 5;
  - `done` in cycle t+7.
- `start` with `x0`=638, `y0`=478, `w`=4, `h`=4:
  - only (638,478), (639,478), (638,479), (639,479) are plotted;
  - `done` still in cycle t+17.
- `start` with `w`=0 → zero plots, `busy` and `done` high for exactly one cycle.
- `clear` and `start` asserted together with `color`=2 → full-screen fill: 307200 plots, last at (639,479).
- `start` pulsed while busy and the inputs changed mid-fill → the pulse is ignored and the original rectangle completes unchanged.
